// File: rtl/floatingpoint.sv
// Shared IEEE-754 single-precision types used by the floating-point adder
// datapath and the primitives it is built from.
package floatingpoint;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float;

  // Exponent value reserved for infinities and NaNs.
  localparam logic [7:0] EXP_SPECIAL = 8'hFF;

endpackage

// File: rtl/fp_arith_primitives_if.sv
// Bundle of operand, result and strobe signals for fp_arith_primitives.
// The block drives the slave side; the producer/consumer uses the master side.
interface fp_arith_primitives_if #(
  parameter int WIDTH       = 8,
  parameter int SHIFT_WIDTH = 32
);
  import floatingpoint::*;

  localparam int AMT_WIDTH = $clog2(SHIFT_WIDTH);

  // Handshake: InputValid has no ready partner; every cycle it is high the
  // inputs are consumed, and exactly one edge later ResultValid is high for
  // one cycle with the matching results. There is no backpressure, so the
  // consumer must take the outputs in the cycle ResultValid is high.
  logic                   InputValid;
  logic [WIDTH-1:0]       A;
  logic [WIDTH-1:0]       B;
  logic                   Sub;
  logic [SHIFT_WIDTH-1:0] ShiftIn;
  logic [AMT_WIDTH-1:0]   ShiftAmt;
  logic                   Rotate;
  logic                   Left;
  float                   Op1;
  float                   Op2;

  logic [WIDTH-1:0]       Sum;
  logic                   CarryOut;
  logic                   Negative;
  logic                   Zero;
  logic                   Overflow;
  logic [SHIFT_WIDTH-1:0] ShiftOut;
  logic                   Op1Invalid;
  logic                   Op2Invalid;
  logic                   InputInvalid;
  logic                   ResultValid;

  modport master (
    output InputValid, A, B, Sub, ShiftIn, ShiftAmt, Rotate, Left, Op1, Op2,
    input  Sum, CarryOut, Negative, Zero, Overflow, ShiftOut,
           Op1Invalid, Op2Invalid, InputInvalid, ResultValid
  );

  modport slave (
    input  InputValid, A, B, Sub, ShiftIn, ShiftAmt, Rotate, Left, Op1, Op2,
    output Sum, CarryOut, Negative, Zero, Overflow, ShiftOut,
           Op1Invalid, Op2Invalid, InputInvalid, ResultValid
  );

endinterface

// File: rtl/AddSub8Bit.sv
// Unsigned add/subtract with carry, borrow, zero and two's-complement
// overflow flags. Purely combinational.
module AddSub8Bit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Sub,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut,
  output logic             Negative,
  output logic             Zero,
  output logic             Overflow
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   total;

  // Subtract is A + ~B + 1, so CarryOut=1 means no borrow (A >= B).
  assign b_eff = Sub ? ~B : B;
  assign total = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, Sub};

  assign {CarryOut, Sum} = total;
  assign Negative = Sub & ~CarryOut;
  assign Zero     = (Sum == '0);
  assign Overflow = (A[WIDTH-1] == b_eff[WIDTH-1]) & (Sum[WIDTH-1] != A[WIDTH-1]);

endmodule

// File: rtl/BarrelShifter.sv
// Logical shift or rotate, left or right, by a variable distance.
// Purely combinational.
module BarrelShifter #(
  parameter int SHIFT_WIDTH = 32,
  parameter int AMT_WIDTH   = $clog2(SHIFT_WIDTH)
) (
  input  logic [SHIFT_WIDTH-1:0] ShiftIn,
  input  logic [AMT_WIDTH-1:0]   ShiftAmt,
  input  logic                   Rotate,
  input  logic                   Left,
  output logic [SHIFT_WIDTH-1:0] ShiftOut
);

  logic [SHIFT_WIDTH-1:0] fill;
  logic [SHIFT_WIDTH-1:0] left_res;
  logic [SHIFT_WIDTH-1:0] right_res;
  logic [SHIFT_WIDTH-1:0] unused_lo;
  logic [SHIFT_WIDTH-1:0] unused_hi;

  // A second copy of the data next to it turns a double-width shift into a
  // rotate; a zero copy gives a plain logical shift.
  assign fill = Rotate ? ShiftIn : '0;
  assign {left_res, unused_lo}  = {ShiftIn, fill} << ShiftAmt;
  assign {unused_hi, right_res} = {fill, ShiftIn} >> ShiftAmt;

  assign ShiftOut = Left ? left_res : right_res;

endmodule

// File: rtl/CheckSpecial.sv
// Flags single-precision operands that are infinity or NaN (all-ones
// exponent). Zero and denormals are treated as ordinary values.
module CheckSpecial
  import floatingpoint::*;
(
  input  float Op1,
  input  float Op2,
  output logic Op1Invalid,
  output logic Op2Invalid,
  output logic InputInvalid
);

  logic unused_fields;

  assign Op1Invalid   = (Op1.exponent == EXP_SPECIAL);
  assign Op2Invalid   = (Op2.exponent == EXP_SPECIAL);
  assign InputInvalid = Op1Invalid | Op2Invalid;

  // Sign and mantissa do not affect the screening result.
  assign unused_fields = ^{Op1.sign, Op1.mantissa, Op2.sign, Op2.mantissa};

endmodule

// File: rtl/fp_arith_primitives.sv
// Registers the add/sub, barrel-shift and special-value results of one
// accepted input together, one cycle after InputValid.
module fp_arith_primitives #(
  parameter int WIDTH       = 8,
  parameter int SHIFT_WIDTH = 32
) (
  input logic                Clock,
  input logic                Reset,
  fp_arith_primitives_if.slave bus
);

  logic [WIDTH-1:0]       sum_c;
  logic                   carry_c;
  logic                   neg_c;
  logic                   zero_c;
  logic                   ovf_c;
  logic [SHIFT_WIDTH-1:0] shift_c;
  logic                   op1_inv_c;
  logic                   op2_inv_c;
  logic                   in_inv_c;

  AddSub8Bit #(.WIDTH(WIDTH)) u_addsub (
    .A        (bus.A),
    .B        (bus.B),
    .Sub      (bus.Sub),
    .Sum      (sum_c),
    .CarryOut (carry_c),
    .Negative (neg_c),
    .Zero     (zero_c),
    .Overflow (ovf_c)
  );

  BarrelShifter #(.SHIFT_WIDTH(SHIFT_WIDTH)) u_shift (
    .ShiftIn  (bus.ShiftIn),
    .ShiftAmt (bus.ShiftAmt),
    .Rotate   (bus.Rotate),
    .Left     (bus.Left),
    .ShiftOut (shift_c)
  );

  CheckSpecial u_special (
    .Op1          (bus.Op1),
    .Op2          (bus.Op2),
    .Op1Invalid   (op1_inv_c),
    .Op2Invalid   (op2_inv_c),
    .InputInvalid (in_inv_c)
  );

  // All results load on the same edge so flags never mix operands across
  // cycles; reset wins over a simultaneous InputValid.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      bus.Sum          <= '0;
      bus.CarryOut     <= 1'b0;
      bus.Negative     <= 1'b0;
      bus.Zero         <= 1'b0;
      bus.Overflow     <= 1'b0;
      bus.ShiftOut     <= '0;
      bus.Op1Invalid   <= 1'b0;
      bus.Op2Invalid   <= 1'b0;
      bus.InputInvalid <= 1'b0;
      bus.ResultValid  <= 1'b0;
    end else begin
      bus.ResultValid <= bus.InputValid;
      if (bus.InputValid) begin
        bus.Sum          <= sum_c;
        bus.CarryOut     <= carry_c;
        bus.Negative     <= neg_c;
        bus.Zero         <= zero_c;
        bus.Overflow     <= ovf_c;
        bus.ShiftOut     <= shift_c;
        bus.Op1Invalid   <= op1_inv_c;
        bus.Op2Invalid   <= op2_inv_c;
        bus.InputInvalid <= in_inv_c;
      end
    end
  end

endmodule

// File: tb/tb_fp_arith_primitives.sv
// Randomized scoreboard bench for fp_arith_primitives (WIDTH=8 instance plus
// a WIDTH=24 instance for the wide adder case).
module tb_fp_arith_primitives;
  import floatingpoint::*;

  localparam int W  = 8;
  localparam int SW = 32;
  localparam int AW = $clog2(SW);
  localparam int EW = W + 4 + SW + 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cycle = 0;
  int   n_vec = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  logic [EW-1:0] exp_q[$];
  int            stamp_q[$];
  logic [EW-1:0] hold_val = '0;
  logic [EW-1:0] mon_exp;
  int            mon_stamp;

  fp_arith_primitives_if #(.WIDTH(W),  .SHIFT_WIDTH(SW)) dut_if ();
  fp_arith_primitives_if #(.WIDTH(24), .SHIFT_WIDTH(SW)) dut24_if ();

  fp_arith_primitives #(.WIDTH(W), .SHIFT_WIDTH(SW)) dut (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (dut_if)
  );

  fp_arith_primitives #(.WIDTH(24), .SHIFT_WIDTH(SW)) dut24 (
    .Clock (clk),
    .Reset (rst_n),
    .bus   (dut24_if)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  function automatic logic [EW-1:0] observed();
    return {dut_if.Sum, dut_if.CarryOut, dut_if.Negative, dut_if.Zero, dut_if.Overflow,
            dut_if.ShiftOut, dut_if.Op1Invalid, dut_if.Op2Invalid, dut_if.InputInvalid};
  endfunction

  // ---------------- reference model ----------------
  // Returns {sum[23:0], carry, negative, zero, overflow} for a w-bit unit.
  function automatic logic [27:0] add_ref(input int w, input longint a, input longint b, input bit sub);
    longint m, raw, sa, sb, sres;
    logic [23:0] s;
    bit c;
    m    = longint'(1) << w;
    raw  = sub ? a - b : a + b;
    c    = sub ? (a >= b) : (raw >= m);
    s    = 24'((raw + m) % m);
    sa   = (a >= m / 2) ? a - m : a;
    sb   = (b >= m / 2) ? b - m : b;
    sres = sub ? sa - sb : sa + sb;
    return {s, c, (sub && (a < b)), (s == 24'd0), ((sres < -(m / 2)) || (sres >= m / 2))};
  endfunction

  function automatic logic [SW-1:0] shift_ref(input logic [SW-1:0] x, input int amt, input bit rot, input bit left);
    logic [SW-1:0] r;
    int j;
    for (int i = 0; i < SW; i++) begin
      j = left ? i - amt : i + amt;
      if (j >= 0 && j < SW) r[i] = x[j];
      else if (rot)         r[i] = x[left ? j + SW : j - SW];
      else                  r[i] = 1'b0;
    end
    return r;
  endfunction

  function automatic bit is_special(input logic [31:0] v);
    float f;
    f = v;
    return f.exponent == 8'hFF;
  endfunction

  function automatic logic [EW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                                          input logic [SW-1:0] sin, input int amt, input bit rot,
                                          input bit left, input logic [31:0] o1, input logic [31:0] o2);
    logic [27:0] r;
    bit i1, i2;
    r  = add_ref(W, longint'(a), longint'(b), sub);
    i1 = is_special(o1);
    i2 = is_special(o2);
    return {r[4+W-1:4], r[3:0], shift_ref(sin, amt, rot, left), i1, i2, i1 | i2};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_fields(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                              input logic [SW-1:0] sin, input logic [AW-1:0] amt, input bit rot,
                              input bit left, input logic [31:0] o1, input logic [31:0] o2);
    dut_if.A = a;  dut_if.B = b;  dut_if.Sub = sub;
    dut_if.ShiftIn = sin;  dut_if.ShiftAmt = amt;  dut_if.Rotate = rot;  dut_if.Left = left;
    dut_if.Op1 = o1;  dut_if.Op2 = o2;
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit sub,
                       input logic [SW-1:0] sin, input logic [AW-1:0] amt, input bit rot,
                       input bit left, input logic [31:0] o1, input logic [31:0] o2);
    @(posedge clk); #1;
    drive_fields(a, b, sub, sin, amt, rot, left, o1, o2);
    dut_if.InputValid = 1'b1;
    exp_q.push_back(model(a, b, sub, sin, int'(amt), rot, left, o1, o2));
    stamp_q.push_back(cycle);
  endtask

  task automatic randomize_fields();
    drive_fields(W'($urandom), W'($urandom), 1'($urandom), $urandom, AW'($urandom),
                 1'($urandom), 1'($urandom), $urandom, $urandom);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    dut_if.InputValid = 1'b0;
    randomize_fields();
  endtask

  task automatic issue_random();
    logic [W-1:0] a, b;
    logic [31:0] o1, o2;
    a  = W'($urandom);
    b  = ($urandom_range(0, 7) == 0) ? a : W'($urandom);
    o1 = $urandom;
    o2 = $urandom;
    if ($urandom_range(0, 3) == 0) o1[30:23] = 8'hFF;
    if ($urandom_range(0, 3) == 0) o2[30:23] = 8'hFF;
    issue(a, b, 1'($urandom), $urandom, AW'($urandom_range(0, SW - 1)),
          1'($urandom), 1'($urandom), o1, o2);
  endtask

  // Reset and InputValid together: the offered input must be dropped.
  task automatic reset_with_valid();
    @(posedge clk); #1;
    randomize_fields();
    rst_n = 1'b0;
    dut_if.InputValid = 1'b1;
    @(posedge clk); #1;
    hold_val = '0;
    rst_n = 1'b1;
    dut_if.InputValid = 1'b0;
  endtask

  task automatic check24(input logic [23:0] a, input logic [23:0] b, input bit sub);
    logic [27:0] r;
    @(posedge clk); #1;
    dut24_if.A = a;  dut24_if.B = b;  dut24_if.Sub = sub;
    dut24_if.InputValid = 1'b1;
    @(posedge clk); #1;
    dut24_if.InputValid = 1'b0;
    @(negedge clk);
    r = add_ref(24, longint'(a), longint'(b), sub);
    n_vec++;
    if ({dut24_if.Sum, dut24_if.CarryOut, dut24_if.Negative, dut24_if.Zero, dut24_if.Overflow} !== r) begin
      n_err++;
      $display("FAIL add24 a=%h b=%h sub=%0d: got %h, expected %h", a, b, sub,
               {dut24_if.Sum, dut24_if.CarryOut, dut24_if.Negative, dut24_if.Zero, dut24_if.Overflow}, r);
    end
    n_vec++;
    if (dut24_if.ResultValid !== 1'b1) begin
      n_err++;
      $display("FAIL valid24: got %b, expected 1", dut24_if.ResultValid);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (dut_if.ResultValid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid at cycle %0d: got 1, expected 0", cycle);
        end else begin
          mon_exp   = exp_q.pop_front();
          mon_stamp = stamp_q.pop_front();
          n_vec++;
          if (observed() !== mon_exp) begin
            n_err++;
            $display("FAIL result at cycle %0d: got %h, expected %h", cycle, observed(), mon_exp);
          end
          n_vec++;
          if (cycle != mon_stamp + 1) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, expected 1", cycle - mon_stamp);
          end
          hold_val = mon_exp;
        end
      end else begin
        n_vec++;
        if (dut_if.ResultValid !== 1'b0 || observed() !== hold_val) begin
          n_err++;
          $display("FAIL hold at cycle %0d: got valid=%b data=%h, expected valid=0 data=%h",
                   cycle, dut_if.ResultValid, observed(), hold_val);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    dut_if.InputValid = 1'b0;
    randomize_fields();
    dut24_if.InputValid = 1'b0;
    dut24_if.A = '0;  dut24_if.B = '0;  dut24_if.Sub = 1'b0;
    dut24_if.ShiftIn = '0;  dut24_if.ShiftAmt = '0;  dut24_if.Rotate = 1'b0;  dut24_if.Left = 1'b0;
    dut24_if.Op1 = '0;  dut24_if.Op2 = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (observed() !== '0 || dut_if.ResultValid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b data=%h, expected all 0", dut_if.ResultValid, observed());
    end
    n_vec++;
    if (dut24_if.Sum !== '0 || dut24_if.ResultValid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state24: got sum=%h valid=%b, expected 0", dut24_if.Sum, dut24_if.ResultValid);
    end
    @(posedge clk); #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // Directed cases, single pulses separated by idle cycles.
    issue(8'd200, 8'd55, 1'b1, 32'h00C00001, 5'd4, 1'b0, 1'b1, 32'h7F800000, 32'h3F800000);
    repeat (2) idle_cycle();
    issue(8'd5,   8'd9,  1'b1, 32'h00C00001, 5'd4, 1'b0, 1'b0, 32'hFFC00000, 32'h00000001);
    idle_cycle();
    issue(8'h40, 8'h40, 1'b0, 32'h80000001, 5'd8, 1'b1, 1'b1, 32'h00000001, 32'hFF800000);
    idle_cycle();
    issue(8'h80, 8'h80, 1'b0, 32'hDEADBEEF, 5'd0, 1'b1, 1'b0, 32'h00000000, 32'h80000000);
    idle_cycle();
    issue(8'h7F, 8'h80, 1'b1, 32'h80000001, 5'd1, 1'b1, 1'b0, 32'h7FFFFFFF, 32'h00800000);
    idle_cycle();
    // Three back-to-back inputs.
    issue(8'h00, 8'h01, 1'b1, 32'h12345678, 5'd31, 1'b0, 1'b1, 32'h3F800000, 32'h7F800001);
    issue(8'hFF, 8'h01, 1'b0, 32'h12345678, 5'd31, 1'b1, 1'b0, 32'h3F800000, 32'h3F800000);
    issue(8'h33, 8'h33, 1'b1, 32'hA5A5A5A5, 5'd0, 1'b0, 1'b0, 32'h7F800000, 32'hFF800000);
    repeat (3) idle_cycle();

    // Reset arriving with a pending input discards it.
    issue(8'h12, 8'h34, 1'b0, 32'hFFFFFFFF, 5'd3, 1'b0, 1'b1, 32'h7F800000, 32'h7F800000);
    reset_with_valid();
    @(negedge clk);
    n_vec++;
    if (observed() !== '0 || dut_if.ResultValid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_with_valid: got valid=%b data=%h, expected all 0", dut_if.ResultValid, observed());
    end
    repeat (2) idle_cycle();

    // Randomized traffic with random gaps.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 9) < 7) issue_random();
      else idle_cycle();
    end
    repeat (3) idle_cycle();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
    end

    // Wide adder instance.
    check24(24'h800000, 24'h7FFFFF, 1'b1);
    n_vec++;
    if (dut24_if.Sum !== 24'd1 || dut24_if.CarryOut !== 1'b1 || dut24_if.Negative !== 1'b0 || dut24_if.Zero !== 1'b0) begin
      n_err++;
      $display("FAIL add24_plan: got sum=%h c=%b n=%b z=%b, expected sum=000001 c=1 n=0 z=0",
               dut24_if.Sum, dut24_if.CarryOut, dut24_if.Negative, dut24_if.Zero);
    end
    check24(24'h7FFFFF, 24'h000001, 1'b0);
    check24(24'h000000, 24'h000001, 1'b1);
    check24(24'hFFFFFF, 24'h000001, 1'b0);
    for (int k = 0; k < 30; k++) begin
      check24(24'($urandom), 24'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_arith_primitives.md
# fp_arith_primitives

Registered utility block bundling the three combinational primitives that the floating-point adder datapath is built from: a parameterized add/subtract unit with status flags, a barrel shifter, and an IEEE-754 single-precision special-value detector. All three evaluate in parallel on every accepted input and their results appear together one clock later with a valid strobe. The adder uses it for exponent comparison, mantissa add/subtract, normalization shifts and input screening.

## Interface
- `WIDTH`, default 8: add/sub operand and result width.
- `SHIFT_WIDTH`, default 32: shifter data width. The shift-amount width is `$clog2(SHIFT_WIDTH)`.
- `Clock`  in  1: sole clock, rising edge.
- `Reset`  in  1: synchronous, active-low reset.
- `InputValid`  in  1: capture all inputs at this edge.
- `A`, `B`  in  WIDTH: adder operands, unsigned.
- `Sub`  in  1: 0 selects A+B, 1 selects A−B.
- `ShiftIn`  in  SHIFT_WIDTH: shifter data.
- `ShiftAmt`  in  `$clog2(SHIFT_WIDTH)`: shift distance.
- `Rotate`  in  1: 0 selects a logical shift (zero fill), 1 selects rotate.
- `Left`  in  1: 1 shifts or rotates left, 0 right.
- `Op1`, `Op2`  in  32 (`float`): operands to screen.
- `Sum`  out  WIDTH: add/sub result.
- `CarryOut`  out  1: adder carry out.
- `Negative`  out  1: unsigned borrow, meaning A<B during subtract.
- `Zero`  out  1: Sum==0.
- `Overflow`  out  1: two's-complement overflow.
- `ShiftOut`  out  SHIFT_WIDTH: shifter result.
- `Op1Invalid`, `Op2Invalid`, `InputInvalid`  out  1: special-value flags.
- `ResultValid`  out  1: results updated this cycle.

## Operation
- **Adder.** Let B' = Sub ? ~B : B. Then {CarryOut, Sum} = A + B' + Sub, computed in WIDTH+1 bits.
  - For subtract, CarryOut=1 means A≥B unsigned.
- **Negative** = Sub & ~CarryOut. It is always 0 when Sub=0.
- **Zero** = (Sum == 0), for both add and subtract.
- **Overflow** = (A[MSB] == B'[MSB]) & (Sum[MSB] != A[MSB]).
- **Shifter.**
  - Rotate=0: logical shift of ShiftIn by ShiftAmt in the direction given by Left, with vacated bits filled with 0.
  - Rotate=1: circular rotate in the same direction.
  - ShiftAmt=0 passes ShiftIn unchanged.
- **Special check.** OpNInvalid = (OpN.exponent == 8'hFF). This covers ±Inf and every NaN, regardless of sign or mantissa.
  - Denormals and zero are valid.
  - InputInvalid = Op1Invalid | Op2Invalid.
- All status outputs are derived from the same captured operands as Sum and ShiftOut. They are never mixed across cycles.

## Timing
- The combinational cores feed one output register stage, so latency is 1 cycle.
- **Capture.** On a rising edge with Reset=1 and InputValid=1, all data and flag outputs load the new results. ResultValid loads 1.
- **Hold.** On a rising edge with Reset=1 and InputValid=0, data and flag outputs hold their values. ResultValid loads 0.
  - ResultValid is therefore a one-cycle pulse per accepted input.
  - Throughput is one input per cycle. Back-to-back InputValid keeps ResultValid high continuously.
- **Reset.** On a rising edge with Reset=0, every output clears to 0, including ResultValid. Reset overrides a simultaneous InputValid.
  - If reset arrives with a result pending, that result is discarded.
- There is no backpressure. The consumer must sample outputs while ResultValid=1.

## Structure
- The `float` packed struct (sign, exponent[7:0], mantissa[22:0]) lives in the shared `floatingpoint` package. The constant `EXP_SPECIAL = 8'hFF` lives there too.
- Three purely combinational sub-modules are instantiated by this block and reused directly by the adder datapath:
  - `AddSub8Bit #(WIDTH)`
  - `BarrelShifter #(SHIFT_WIDTH)`
  - `CheckSpecial`
- The top level contains only the output registers and the valid flop.

## Test plan
- **Subtract, no overflow.** WIDTH=8, A=200, B=55, Sub=1 → Sum=145, CarryOut=1, Negative=0, Zero=0, Overflow=0.
- **Borrow and overflow cases.**
  - A=5, B=9, Sub=1 → Sum=8'hFC, CarryOut=0, Negative=1.
  - A=B=8'h40, Sub=0 → Sum=8'h80, Overflow=1, CarryOut=0.
  - A=B=8'h80, Sub=0 → Sum=0, Zero=1, CarryOut=1, Overflow=1.
- **Shifter.**
  - ShiftIn=32'h00C00001, ShiftAmt=4, Rotate=0, Left=1 → 32'h0C000010.
  - Same input with Left=0 → 32'h000C0000.
  - ShiftIn=32'h80000001, ShiftAmt=8, Rotate=1, Left=1 → 32'h00000180.
  - Any input with ShiftAmt=0 → passthrough.
- **Special check.**
  - Op1=32'h7F800000 (+Inf), Op2=32'h3F800000 (1.0) → Op1Invalid=1, Op2Invalid=0, InputInvalid=1.
  - Op1=32'hFFC00000 (NaN) → 1.
  - Op1=32'h00000001 (denormal) → 0.
- **Handshake and reset.**
  - A single InputValid pulse → ResultValid high for exactly one cycle, one edge later; outputs hold afterwards.
  - Three consecutive InputValid cycles → ResultValid high for three cycles.
  - Reset=0 together with InputValid=1 → all outputs 0 next cycle.
- **WIDTH=24 instance.** A=24'h800000, B=24'h7FFFFF, Sub=1 → Sum=1, CarryOut=1, Negative=0, Zero=0.
